// File: rtl/pim_tile_scheduler_pkg.sv
// Shared types for the PIM tile scheduler: pool defaults, FSM states,
// tile coordinate payload and the row-major coordinate stepping helper.
package pim_tile_scheduler_pkg;

    localparam int unsigned NUM_PIM_DEF       = 4;
    localparam int unsigned MAX_TILES_DIM_DEF = 4;
    // Internal coordinate width; covers MAX_TILES_DIM up to 15.
    localparam int unsigned COORD_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } tile_coord_t;

    // Advance one tile in row-major order across a dim x dim grid.
    function automatic tile_coord_t coord_step(input tile_coord_t pos,
                                               input logic [COORD_W-1:0] dim);
        tile_coord_t nxt;
        if (pos.col + COORD_W'(1) == dim) begin
            nxt.row = pos.row + COORD_W'(1);
            nxt.col = '0;
        end else begin
            nxt.row = pos.row;
            nxt.col = pos.col + COORD_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pim_tile_scheduler_prio_enc.sv
// Lowest-index-set priority encoder.
// Ports: req (request mask), idx_c (index of lowest set bit), found_c (any bit set).
module pim_prio_enc #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx_c,
    output logic         found_c
);

    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found_c) begin
                idx_c   = W'(i);
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pim_tile_scheduler.sv
// Tiled matmul scheduler: walks output tiles row-major, dispatches each to the
// lowest free PIM unit, serialises unit completions into one capture strobe
// per cycle for the aggregator and pulses result_ready when all tiles land.
// Ports: clk/rst (async active-low); start/abort/cfg_tiles_dim job control;
// pim_valid/pim_tile_row/pim_tile_col dispatch and pim_done completion per
// unit; agg_wr/agg_unit/agg_tile_row/agg_tile_col capture strobe;
// busy, result_ready, tiles_done status.
module pim_tile_scheduler
    import pim_tile_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_PIM       = NUM_PIM_DEF,
    parameter  int unsigned MAX_TILES_DIM = MAX_TILES_DIM_DEF,
    localparam int unsigned TW = (MAX_TILES_DIM > 1) ? $clog2(MAX_TILES_DIM) : 1,
    localparam int unsigned UW = (NUM_PIM > 1) ? $clog2(NUM_PIM) : 1,
    localparam int unsigned DW = TW + 1,
    localparam int unsigned CW = 2 * TW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DW-1:0]         cfg_tiles_dim,
    output logic [NUM_PIM-1:0]    pim_valid,
    output logic [NUM_PIM*TW-1:0] pim_tile_row,
    output logic [NUM_PIM*TW-1:0] pim_tile_col,
    input  logic [NUM_PIM-1:0]    pim_done,
    output logic                  agg_wr,
    output logic [UW-1:0]         agg_unit,
    output logic [TW-1:0]         agg_tile_row,
    output logic [TW-1:0]         agg_tile_col,
    output logic                  busy,
    output logic                  result_ready,
    output logic [CW-1:0]         tiles_done
);

    sched_state_e         state;
    logic [DW-1:0]        dim;
    logic [CW-1:0]        total;
    logic [CW-1:0]        next_tile;
    tile_coord_t          next_pos;
    logic [NUM_PIM-1:0]   unit_busy;
    logic [NUM_PIM-1:0]   pend;

    logic [DW-1:0]        cfg_dim;
    logic [CW-1:0]        cfg_total;
    tile_coord_t          first_step;
    tile_coord_t          next_step;
    logic [NUM_PIM-1:0]   pend_all;
    logic [UW-1:0]        fwd_idx;
    logic                 fwd_found;
    logic [UW-1:0]        free_idx;
    logic                 free_found;
    logic                 disp_ok;
    logic [NUM_PIM-1:0]   disp_mask;
    logic [NUM_PIM-1:0]   fwd_mask;
    logic [TW-1:0]        fwd_row;
    logic [TW-1:0]        fwd_col;

    // Clamp the requested grid size into 1..MAX_TILES_DIM.
    always_comb begin
        cfg_dim = cfg_tiles_dim;
        if (cfg_tiles_dim == '0) begin
            cfg_dim = DW'(1);
        end else if (cfg_tiles_dim > DW'(MAX_TILES_DIM)) begin
            cfg_dim = DW'(MAX_TILES_DIM);
        end
        cfg_total  = CW'(cfg_dim) * CW'(cfg_dim);
        first_step = coord_step('0, COORD_W'(cfg_dim));
        next_step  = coord_step(next_pos, COORD_W'(dim));
    end

    // Fresh completions from busy, not-yet-pending units join the pending set
    // in the same cycle so a lone done is forwarded with one cycle of latency.
    assign pend_all = pend | (pim_done & unit_busy & ~pend);

    pim_prio_enc #(.N(NUM_PIM)) u_pend_enc (
        .req     (pend_all),
        .idx_c   (fwd_idx),
        .found_c (fwd_found)
    );

    pim_prio_enc #(.N(NUM_PIM)) u_free_enc (
        .req     (~unit_busy),
        .idx_c   (free_idx),
        .found_c (free_found)
    );

    // Dispatch and forward masks; disjoint because one uses free units, one busy.
    always_comb begin
        disp_ok   = (next_tile < total) && free_found;
        disp_mask = disp_ok ? (NUM_PIM'(1) << free_idx) : '0;
        fwd_mask  = fwd_found ? (NUM_PIM'(1) << fwd_idx) : '0;
        fwd_row   = '0;
        fwd_col   = '0;
        for (int i = 0; i < NUM_PIM; i++) begin
            if (UW'(i) == fwd_idx) begin
                fwd_row = pim_tile_row[i*TW +: TW];
                fwd_col = pim_tile_col[i*TW +: TW];
            end
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            dim          <= '0;
            total        <= '0;
            next_tile    <= '0;
            next_pos     <= '0;
            unit_busy    <= '0;
            pend         <= '0;
            pim_valid    <= '0;
            pim_tile_row <= '0;
            pim_tile_col <= '0;
            agg_wr       <= 1'b0;
            agg_unit     <= '0;
            agg_tile_row <= '0;
            agg_tile_col <= '0;
            busy         <= 1'b0;
            result_ready <= 1'b0;
            tiles_done   <= '0;
        end else begin
            pim_valid    <= '0;
            agg_wr       <= 1'b0;
            result_ready <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                busy         <= 1'b0;
                unit_busy    <= '0;
                pend         <= '0;
                next_tile    <= '0;
                next_pos     <= '0;
                tiles_done   <= '0;
                pim_tile_row <= '0;
                pim_tile_col <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // Accept the job and dispatch tile (0,0) to unit 0 at once.
                        if (start) begin
                            state                 <= RUN;
                            busy                  <= 1'b1;
                            dim                   <= cfg_dim;
                            total                 <= cfg_total;
                            next_tile             <= CW'(1);
                            next_pos              <= first_step;
                            unit_busy             <= NUM_PIM'(1);
                            pend                  <= '0;
                            tiles_done            <= '0;
                            pim_valid             <= NUM_PIM'(1);
                            pim_tile_row[TW-1:0]  <= '0;
                            pim_tile_col[TW-1:0]  <= '0;
                        end
                    end
                    RUN: begin
                        if (tiles_done == total) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            result_ready <= 1'b1;
                        end else begin
                            unit_busy <= (unit_busy | disp_mask) & ~fwd_mask;
                            pend      <= pend_all & ~fwd_mask;
                            pim_valid <= disp_mask;
                            for (int i = 0; i < NUM_PIM; i++) begin
                                if (disp_mask[i]) begin
                                    pim_tile_row[i*TW +: TW] <= TW'(next_pos.row);
                                    pim_tile_col[i*TW +: TW] <= TW'(next_pos.col);
                                end
                            end
                            if (disp_ok) begin
                                next_tile <= next_tile + CW'(1);
                                next_pos  <= next_step;
                            end
                            if (fwd_found) begin
                                agg_wr       <= 1'b1;
                                agg_unit     <= fwd_idx;
                                agg_tile_row <= fwd_row;
                                agg_tile_col <= fwd_col;
                                tiles_done   <= tiles_done + CW'(1);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pim_tile_scheduler.sv
// Directed bench for pim_tile_scheduler: a 4-unit and a 2-unit instance,
// a latency-based PIM unit model, and per-kind expected-event queues
// (dispatch, capture, result_ready) checked with cycle stamps.
module tb_pim_tile_scheduler;

    typedef struct {
        int cyc;
        int unit;
        int row;
        int col;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [2:0] cfg = '0;
    logic sel = 1'b0;
    int lat = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    ev_t dq[$];
    ev_t aq[$];
    ev_t rq[$];
    ev_t e;

    // 4-unit instance signals
    logic [3:0] v4, done4, auto4, man4;
    logic [7:0] trow4, tcol4;
    logic       agg_wr4, busy4, rr4;
    logic [1:0] au4, arow4, acol4;
    logic [4:0] td4;
    // 2-unit instance signals
    logic [1:0] v2, done2, auto2;
    logic [3:0] trow2, tcol2;
    logic       agg_wr2, busy2, rr2;
    logic [0:0] au2;
    logic [1:0] arow2, acol2;
    logic [4:0] td2;

    int due4[4];
    int due2[2];

    // Observed view of whichever instance the current step exercises.
    logic [3:0] m_valid;
    logic [7:0] m_trow, m_tcol;
    logic       m_agg, m_busy, m_rr;
    logic [1:0] m_unit, m_arow, m_acol;
    logic [4:0] m_td;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign done4 = auto4 | man4;
    assign done2 = auto2;

    assign m_valid = sel ? {2'b00, v2} : v4;
    assign m_trow  = sel ? {4'b0, trow2} : trow4;
    assign m_tcol  = sel ? {4'b0, tcol2} : tcol4;
    assign m_agg   = sel ? agg_wr2 : agg_wr4;
    assign m_unit  = sel ? {1'b0, au2} : au4;
    assign m_arow  = sel ? arow2 : arow4;
    assign m_acol  = sel ? acol2 : acol4;
    assign m_busy  = sel ? busy2 : busy4;
    assign m_rr    = sel ? rr2 : rr4;
    assign m_td    = sel ? td2 : td4;

    pim_tile_scheduler u_dut4 (
        .clk (clk), .rst (rst), .start (start & ~sel), .abort (abort),
        .cfg_tiles_dim (cfg), .pim_valid (v4), .pim_tile_row (trow4),
        .pim_tile_col (tcol4), .pim_done (done4), .agg_wr (agg_wr4),
        .agg_unit (au4), .agg_tile_row (arow4), .agg_tile_col (acol4),
        .busy (busy4), .result_ready (rr4), .tiles_done (td4)
    );

    pim_tile_scheduler #(.NUM_PIM(2), .MAX_TILES_DIM(4)) u_dut2 (
        .clk (clk), .rst (rst), .start (start & sel), .abort (abort),
        .cfg_tiles_dim (cfg), .pim_valid (v2), .pim_tile_row (trow2),
        .pim_tile_col (tcol2), .pim_done (done2), .agg_wr (agg_wr2),
        .agg_unit (au2), .agg_tile_row (arow2), .agg_tile_col (acol2),
        .busy (busy2), .result_ready (rr2), .tiles_done (td2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steady-state schedule when every unit completes lat_v cycles after dispatch
    // and n <= lat_v+2: unit k%n, one re-dispatch round every lat_v+2 cycles.
    task automatic push_sched(input int base, input int dim_e, input int n, input int lat_v);
        int v;
        int last;
        last = 0;
        for (int k = 0; k < dim_e * dim_e; k++) begin
            v = base + 1 + (k % n) + (k / n) * (lat_v + 2);
            dq.push_back('{v, k % n, k / dim_e, k % dim_e});
            aq.push_back('{v + lat_v + 1, k % n, k / dim_e, k % dim_e});
            last = v + lat_v + 1;
        end
        rq.push_back('{last + 1, dim_e * dim_e, 0, 0});
    endtask

    task automatic run_job(input int cfg_v, input int dim_e, input int n,
                           input int lat_v, input int wait_n);
        int base;
        lat  = lat_v;
        base = cyc;
        push_sched(base, dim_e, n, lat_v);
        start = 1'b1;
        cfg   = 3'(cfg_v);
        @(negedge clk);
        start = 1'b0;
        check("busy_at_start", 64'(m_busy), 64'(1));
        repeat (wait_n) @(negedge clk);
        check("busy_after_job", 64'(m_busy), 64'(0));
        check("tiles_done", 64'(m_td), 64'(dim_e * dim_e));
    endtask

    // PIM unit model: raise done lat cycles after each dispatch.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst) due4[i] = -1;
            auto4[i] = (due4[i] == cyc);
            if (v4[i] && lat > 0) due4[i] = cyc + lat;
        end
        for (int i = 0; i < 2; i++) begin
            if (!rst) due2[i] = -1;
            auto2[i] = (due2[i] == cyc);
            if (v2[i] && lat > 0) due2[i] = cyc + lat;
        end
    end

    // Event monitor: compare each observed event with the head of its queue.
    always @(negedge clk) begin
        if (m_valid != '0) begin
            if (dq.size() == 0) begin
                check("dispatch_unexpected", 64'(m_valid), 64'(0));
            end else begin
                e = dq.pop_front();
                check("dispatch", {32'(cyc), m_valid, 2'(m_trow >> (2 * e.unit)),
                                   2'(m_tcol >> (2 * e.unit))},
                      {32'(e.cyc), 4'(1 << e.unit), 2'(e.row), 2'(e.col)});
            end
        end
        if (m_agg) begin
            if (aq.size() == 0) begin
                check("agg_unexpected", 64'(m_agg), 64'(0));
            end else begin
                e = aq.pop_front();
                check("agg_wr", {32'(cyc), m_unit, m_arow, m_acol},
                      {32'(e.cyc), 2'(e.unit), 2'(e.row), 2'(e.col)});
            end
        end
        if (m_rr) begin
            if (rq.size() == 0) begin
                check("ready_unexpected", 64'(m_rr), 64'(0));
            end else begin
                e = rq.pop_front();
                check("result_ready", {32'(cyc), m_td}, {32'(e.cyc), 5'(e.unit)});
            end
        end
    end

    initial begin
        int base;
        man4 = '0;
        auto4 = '0;
        auto2 = '0;
        repeat (2) @(negedge clk);
        check("rst_flags", 64'({v4, agg_wr4, busy4, rr4}), 64'(0));
        check("rst_counts", 64'({td4, au4, arow4, acol4}), 64'(0));
        check("rst_coords", 64'({trow4, tcol4}), 64'(0));
        check("rst_dut2", 64'({v2, agg_wr2, busy2, rr2, td2}), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // 2x2 grid over four units
        run_job(2, 2, 4, 5, 12);

        // 3x3 grid over two units: re-dispatch one cycle after capture
        sel = 1'b1;
        run_job(3, 3, 2, 5, 37);
        sel = 1'b0;

        // Grid size clamping
        run_job(0, 1, 4, 5, 9);
        run_job(7, 4, 4, 5, 33);

        // Simultaneous completions on units 0,2,3 plus dropped repeats
        lat  = 0;
        base = cyc;
        for (int k = 0; k < 4; k++) dq.push_back('{base + 1 + k, k, k / 2, k % 2});
        aq.push_back('{base + 7, 0, 0, 0});
        aq.push_back('{base + 8, 2, 1, 0});
        aq.push_back('{base + 9, 3, 1, 1});
        aq.push_back('{base + 11, 1, 0, 1});
        rq.push_back('{base + 12, 4, 0, 0});
        start = 1'b1;
        cfg   = 3'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        man4 = 4'b1101;
        @(negedge clk);
        man4 = 4'b0100;
        @(negedge clk);
        man4 = 4'b0001;
        @(negedge clk);
        man4 = 4'b0000;
        @(negedge clk);
        man4 = 4'b0010;
        @(negedge clk);
        man4 = 4'b0000;
        repeat (3) @(negedge clk);
        check("simul_tiles_done", 64'(td4), 64'(4));
        check("simul_idle", 64'(busy4), 64'(0));

        // Abort after two dispatches
        base = cyc;
        dq.push_back('{base + 1, 0, 0, 0});
        dq.push_back('{base + 2, 1, 0, 1});
        start = 1'b1;
        cfg   = 3'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy4), 64'(0));
        check("abort_tiles", 64'(td4), 64'(0));
        repeat (2) @(negedge clk);
        man4 = 4'b0011;
        @(negedge clk);
        man4 = 4'b0000;
        repeat (4) @(negedge clk);
        run_job(2, 2, 4, 5, 12);

        // Reset in the middle of a job
        lat  = 5;
        base = cyc;
        push_sched(base, 4, 4, 5);
        start = 1'b1;
        cfg   = 3'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("midrun_tiles", 64'(td4), 64'(3));
        #2;
        rst = 1'b0;
        #1;
        check("midrst_flags", 64'({v4, agg_wr4, busy4, rr4}), 64'(0));
        check("midrst_counts", 64'({td4, au4, arow4, acol4}), 64'(0));
        check("midrst_coords", 64'({trow4, tcol4}), 64'(0));
        dq.delete();
        aq.delete();
        rq.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_held_busy", 64'(busy4), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Clean job with a spurious done and a stray start while running
        base = cyc;
        push_sched(base, 2, 4, 5);
        start = 1'b1;
        cfg   = 3'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        man4 = 4'b1000;
        @(negedge clk);
        man4  = 4'b0000;
        start = 1'b1;
        cfg   = 3'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("spurious_tiles", 64'(td4), 64'(4));
        check("spurious_idle", 64'(busy4), 64'(0));

        check("dispatch_left", 64'(dq.size()), 64'(0));
        check("agg_left", 64'(aq.size()), 64'(0));
        check("ready_left", 64'(rq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pim_tile_scheduler.md
# pim_tile_scheduler

Sequences a tiled matrix multiply across a pool of PIM units. Given a tile-grid size, it walks the output tiles in row-major order and dispatches each (tile_row, tile_col) job to the lowest-indexed free PIM unit. It serialises unit completions into one-per-cycle capture strobes for the result aggregator, and pulses `result_ready` when every tile has been captured. It sits between the top-level start/result interface and the `pim_unit` instances, and replaces fixed four-unit wiring with a scheduled pool.

## Interface
- `NUM_PIM`, default 4: number of PIM units in the pool (1..8).
- `MAX_TILES_DIM`, default 4: maximum tiles per matrix dimension; `TW = max(1, $clog2(MAX_TILES_DIM))`.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; has priority over all other inputs except reset.
- `cfg_tiles_dim`  in  TW+1  tiles per dimension, sampled on accepted `start`.
  - 0 is treated as 1.
  - Values above MAX_TILES_DIM are clamped to MAX_TILES_DIM.
- `pim_valid`  out  NUM_PIM  one-cycle dispatch pulse per unit.
- `pim_tile_row`, `pim_tile_col`  out  NUM_PIM×TW each  tile coordinates per unit; held while the unit is busy.
- `pim_done`  in  NUM_PIM  one-cycle completion pulse per unit; ignored for non-busy units.
- `agg_wr`  out  1  capture strobe to the aggregator.
- `agg_unit`  out  $clog2(NUM_PIM) (min 1)  unit whose result to capture.
- `agg_tile_row`, `agg_tile_col`  out  TW each  destination tile.
- `busy`  out  1  high in RUN.
- `result_ready`  out  1  one-cycle pulse, job complete.
- `tiles_done`  out  2·TW+1  count of captured tiles in the current job.

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. This latches `total = dim²` and clears `next_tile`, `tiles_done`, `unit_busy` and `pend`.
  - RUN → DONE when `tiles_done == total` (after the final `agg_wr`).
  - DONE → IDLE unconditionally after one cycle; `result_ready` is high only in DONE.
  - `abort` in any state → IDLE next cycle. It clears `unit_busy`, `pend` and counters. No `result_ready`, no further `agg_wr`.
- Dispatch (RUN only): at most one dispatch per cycle.
  - Dispatch happens if `next_tile < total` and some unit has `unit_busy == 0`.
  - The job goes to the lowest-index free unit, with row = `next_tile / dim` and col = `next_tile % dim`.
  - Set `unit_busy`, latch the coordinates, pulse `pim_valid`, and increment `next_tile`.
- Completion: `pim_done[i]` with `unit_busy[i]` sets `pend[i]`.
  - Each cycle, the lowest-index pending unit is forwarded: `agg_wr=1`, `agg_unit=i`, and the latched coordinates.
  - Forwarding clears `pend[i]` and `unit_busy[i]` and increments `tiles_done`.
  - Other pending units wait; they stay busy and are not re-dispatched.
- `pim_done` on a non-busy unit, or on an already-pending unit, is dropped. It is not an error.
- `start` outside IDLE is ignored.
- Dispatch selects only from units free at the start of the cycle. A unit forwarded in cycle N is dispatchable in cycle N+1.

## Timing
- All outputs are registered.
- Reset values: all outputs 0. FSM IDLE; `unit_busy`, `pend` and counters 0.
- Start latency: `start` high in cycle 0 → `busy` and the first `pim_valid` in cycle 1.
- Dispatch rate: the k-th tile dispatches in cycle k+1 while free units remain.
- Done latency: `pim_done` in cycle N → `agg_wr` in cycle N+1 if no lower-index unit is pending.
- Completion latency: last `agg_wr` in cycle M → `result_ready` in cycle M+1 → IDLE in M+2. A new `start` is accepted in M+2.
- `pim_done` and `agg_wr` for the same unit in the same cycle cannot occur, because the unit is still busy until it is forwarded.
- Reset asserted mid-job immediately zeroes all outputs and state.

## Structure
- The shared `types` package holds:
  - `NUM_PIM` and `MAX_TILES_DIM` defaults;
  - the `sched_state_e` enum {IDLE, RUN, DONE};
  - a `tile_coord_t` struct {row, col}.
- One sub-module, `pim_prio_enc`: a parameterised lowest-index-set priority encoder with a `found` flag. It is instantiated twice, once for the free-unit mask and once for the pending mask.

## Test plan
- `dim=2`, NUM_PIM=4, each unit raises `pim_done` 5 cycles after its `pim_valid` → dispatches in cycles 1–4 to units 0–3 with coords (0,0),(0,1),(1,0),(1,1); four `agg_wr`; `result_ready` one cycle after the 4th; `tiles_done=4`.
- `dim=3`, NUM_PIM=2 → 9 dispatches; a unit is re-dispatched exactly one cycle after its `agg_wr`; coordinates follow row-major order.
- Simultaneous `pim_done` on units 0, 2 and 3 → `agg_wr` for units 0, 2, 3 in three consecutive cycles; none is lost.
- `cfg_tiles_dim=0` → one tile (0,0) on unit 0. `cfg_tiles_dim=7` with MAX=4 → 16 tiles.
- `abort` after 2 dispatches → IDLE next cycle, `busy=0`, no `result_ready`; a later `pim_done` is ignored; the next `start` runs cleanly.
- `rst` low mid-RUN → all outputs 0 immediately; a spurious `pim_done` and a `start` during RUN produce no effect.
